// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and the
// round-robin helpers that other shared-resource blocks reuse.
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int N_REQ_MAX      = 8;

    // Increment a requester index and wrap it back to zero at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    int pos;

    // Scan from farthest to nearest so the request closest to ptr is written last and wins.
    always_comb begin
        idx = '0;
        pos = 0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            idx = req[IDX_W'(pos)] ? IDX_W'(pos) : idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of the single UART transmitter. A grant is
// held for a whole message (or up to MAX_BURST bytes) so messages from
// different producers never interleave; the byte path to the transmitter
// is registered.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_CAP = BC_W'(MAX_BURST);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic               tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;

    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               slot_free_s;
    logic               accept_s;
    logic               msg_end_s;
    logic [BC_W-1:0]    burst_inc_s;
    logic [DATA_W-1:0]  sel_data_s;

    rr_pick #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Granted-requester mux and handshake decode; the output slot is free when empty or draining.
    always_comb begin
        sel_data_s  = req_data[int'(grant_q) * DATA_W +: DATA_W];
        slot_free_s = !tx_valid_q || tx_ready;
        accept_s    = (state_q == LOCK) && req_valid[grant_q] && slot_free_s;
        burst_inc_s = burst_cnt_q + BC_W'(1);
        msg_end_s   = req_last[grant_q] || (burst_inc_s == BURST_CAP);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grab on any request, release on last byte or burst cap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (accept_s && msg_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only the granted requester sees ready, and only when the slot can take a byte.
    always_comb begin
        req_ready = '0;
        busy      = (state_q == LOCK);
        if (state_q == LOCK) begin
            req_ready[grant_q] = slot_free_s;
        end else begin
            req_ready = '0;
        end
    end

    // Grant, pointer and burst bookkeeping.
    always_comb begin
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if ((state_q == IDLE) && pick_any_s) begin
            grant_d     = pick_idx_s;
            burst_cnt_d = '0;
        end else if (accept_s) begin
            burst_cnt_d = burst_inc_s;
            if (msg_end_s) begin
                rr_ptr_d = PTR_W'(rr_next(32'(grant_q), unsigned'(N_REQ)));
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Output register: load on accept (replacing a draining byte), clear once drained.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (accept_s) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data_s;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message
// sets, checked against a message-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  pq [N][$];      // per-producer pending bytes, bit 8 = last
    logic [N-1:0] hold;          // producer temporarily withholds valid
    logic [8:0]  exp_bytes [$];  // expected transmitter byte stream
    int          exp_grants [$]; // expected grant order
    int          m_ptr;          // model round-robin pointer
    logic        prev_busy;
    int          txr_pct;
    int          acc_cnt [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b, input logic last);
        pq[id].push_back({last, b});
    endtask

    // Reference: serve producers round-robin, each grant until last byte or MB bytes.
    task automatic plan();
        logic [8:0] cq [N][$];
        int         id;
        int         n;
        logic [8:0] b;
        logic       done;
        for (int i = 0; i < N; i++) cq[i] = pq[i];
        forever begin
            id = -1;
            for (int k = 0; k < N; k++) begin
                if (id < 0 && cq[(m_ptr + k) % N].size() > 0) id = (m_ptr + k) % N;
            end
            if (id < 0) break;
            exp_grants.push_back(id);
            n = 0;
            done = 1'b0;
            while (!done) begin
                b = cq[id].pop_front();
                exp_bytes.push_back({1'b0, b[7:0]});
                n++;
                done = b[8] || (n == MB) || (cq[id].size() == 0);
            end
            m_ptr = (id + 1) % N;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && !hold[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = pq[i][0][7:0];
                req_last[i]           = pq[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
        tx_ready = ($urandom_range(99, 0) < txr_pct);
    endtask

    // One clock: drive at negedge, sample handshakes before posedge, score after it.
    task automatic cycle();
        logic [N-1:0] acc;
        logic         fire;
        logic [7:0]   seen;
        logic [8:0]   eb;
        int           eg;
        drive();
        #3;
        acc  = req_valid & req_ready;
        fire = tx_valid && tx_ready;
        seen = tx_data;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(pq[i].pop_front());
                acc_cnt[i]++;
            end
        end
        if (fire) begin
            if (exp_bytes.size() > 0) eb = exp_bytes.pop_front();
            else eb = 9'h100;
            check("tx_byte", 32'({1'b0, seen}), 32'(eb));
        end
        if (busy && !prev_busy) begin
            if (exp_grants.size() > 0) eg = exp_grants.pop_front();
            else eg = -1;
            check("grant_order", 32'(grant_id), 32'(eg));
        end
        prev_busy = busy;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_bytes.size() > 0 || busy || tx_valid) && n < 300) begin
            cycle();
            n++;
        end
        check({tag, "_leftover"}, 32'(exp_bytes.size() + exp_grants.size() + int'(busy)), 32'(0));
    endtask

    initial begin
        int base;
        int n;
        int nmsg;
        int len;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        hold      = '0;
        txr_pct   = 100;
        m_ptr     = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;

        // Reset values
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Contention: four one-byte messages, pointer at 0
        for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        plan();
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("cont_busy", 32'(busy), 32'(k % 2 == 0));
            if (k % 2 == 0) check("cont_grant", 32'(grant_id), 32'(k / 2));
        end
        drain("cont");

        // Single message from requester 2
        push(2, 8'h48, 1'b0);
        push(2, 8'h69, 1'b1);
        plan();
        check("single_idle", 32'(busy), 32'(0));
        cycle();
        check("single_busy", 32'(busy), 32'(1));
        check("single_grant", 32'(grant_id), 32'(2));
        check("single_ready", 32'(req_ready), 32'(4'b0100));
        cycle();
        check("single_v0", 32'(tx_valid), 32'(1));
        check("single_d0", 32'(tx_data), 32'(8'h48));
        check("single_busy1", 32'(busy), 32'(1));
        cycle();
        check("single_d1", 32'(tx_data), 32'(8'h69));
        check("single_release", 32'(busy), 32'(0));
        drain("single");

        // Backpressure: transmitter stalls for five cycles
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        plan();
        cycle();
        cycle();
        txr_pct = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_ready", 32'(req_ready), 32'(0));
            check("bp_hold", 32'(tx_data), 32'(8'h11));
            check("bp_valid", 32'(tx_valid), 32'(1));
        end
        txr_pct = 100;
        drain("bp");

        // Gap: granted requester 2 withholds valid for three cycles
        for (int b = 0; b < 5; b++) push(2, 8'h51 + 8'(b), b == 4);
        push(0, 8'h60, 1'b1);
        push(3, 8'h70, 1'b1);
        plan();
        base = acc_cnt[2];
        n = 0;
        while (acc_cnt[2] < base + 2 && n < 20) begin
            cycle();
            n++;
        end
        check("gap_start", 32'(acc_cnt[2] - base), 32'(2));
        hold[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("gap_busy", 32'(busy), 32'(1));
            check("gap_grant", 32'(grant_id), 32'(2));
            check("gap_others", 32'(req_ready & 4'b1011), 32'(0));
        end
        hold[2] = 1'b0;
        drain("gap");

        // Reset in the middle of a message
        for (int b = 0; b < 4; b++) push(2, 8'h81 + 8'(b), b == 3);
        plan();
        cycle();
        cycle();
        cycle();
        check("mid_pre_valid", 32'(tx_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_tx_valid", 32'(tx_valid), 32'(0));
        check("mid_tx_data", 32'(tx_data), 32'(0));
        check("mid_req_ready", 32'(req_ready), 32'(0));
        check("mid_grant", 32'(grant_id), 32'(0));
        check("mid_busy", 32'(busy), 32'(0));
        for (int i = 0; i < N; i++) pq[i].delete();
        exp_bytes.delete();
        exp_grants.delete();
        m_ptr = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(0, 8'h90, 1'b1);
        push(3, 8'h93, 1'b1);
        plan();
        cycle();
        check("mid_first_grant", 32'(grant_id), 32'(0));
        drain("mid");

        // Burst cap: requester 1 streams 10 bytes while requester 3 waits
        for (int b = 0; b < 10; b++) push(1, 8'hB1 + 8'(b), b == 9);
        push(3, 8'hD1, 1'b0);
        push(3, 8'hD2, 1'b1);
        plan();
        drain("burst");

        // Randomized message sets with random transmitter backpressure
        for (int r = 0; r < 10; r++) begin
            txr_pct = $urandom_range(100, 30);
            for (int i = 0; i < N; i++) begin
                nmsg = $urandom_range(2, 0);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(7, 1);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            plan();
            drain("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
